// File: rtl/lisnoc_packetizer_if.sv
// Link bundle between a tile-side message client, the packetizer and the
// router local input port. The slave modport is the packetizer's view; the
// master modport is the environment (client plus router) driving it.
interface lisnoc_packetizer_if #(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int VCHANNELS       = 1,
   parameter int VC_WIDTH        = 1,
   parameter int PH_DEST_WIDTH   = 5,
   parameter int PH_PRIO_WIDTH   = 4,
   parameter int LEN_WIDTH       = 8
) ();
   localparam int HDR_WIDTH  = FLIT_DATA_WIDTH - PH_DEST_WIDTH - PH_PRIO_WIDTH;
   localparam int FLIT_WIDTH = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;

   // packet request
   logic                       req_valid;
   logic                       req_ready;
   logic [PH_DEST_WIDTH-1:0]   req_dest;
   logic [PH_PRIO_WIDTH-1:0]   req_prio;
   logic [HDR_WIDTH-1:0]       req_hdr;
   logic [LEN_WIDTH-1:0]       req_len;
   logic [VC_WIDTH-1:0]        req_vc;

   // payload words
   logic [FLIT_DATA_WIDTH-1:0] data_in;
   logic                       data_valid;
   logic                       data_ready;

   // flit link towards the router
   logic [FLIT_WIDTH-1:0]      out_flit;
   logic [VCHANNELS-1:0]       out_valid;
   logic [VCHANNELS-1:0]       out_ready;

   modport master (
      output req_valid, req_dest, req_prio, req_hdr, req_len, req_vc,
      output data_in, data_valid, out_ready,
      input  req_ready, data_ready, out_flit, out_valid
   );

   modport slave (
      input  req_valid, req_dest, req_prio, req_hdr, req_len, req_vc,
      input  data_in, data_valid, out_ready,
      output req_ready, data_ready, out_flit, out_valid
   );
endinterface

// File: rtl/lisnoc_packetizer.sv
// lisnoc_packetizer: turns a request + payload-word stream into lisnoc flits
// (header, payloads, last / single) and injects them into a router local
// input port through a one-flit output register.
// Optional packet counter output stat_packets is enabled by defining
// LISNOC_PACKETIZER_STATS_EN.
module lisnoc_packetizer #(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int VCHANNELS       = 1,
   parameter int VC_WIDTH        = 1,
   parameter int PH_DEST_WIDTH   = 5,
   parameter int PH_PRIO_WIDTH   = 4,
   parameter int LEN_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   lisnoc_packetizer_if.slave   bus
`ifdef LISNOC_PACKETIZER_STATS_EN
   ,
   output logic [31:0]          stat_packets
`endif
);
   localparam int FLIT_WIDTH = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;

   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_PAYLOAD = FLIT_TYPE_WIDTH'(0);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HEADER  = FLIT_TYPE_WIDTH'(1);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_LAST    = FLIT_TYPE_WIDTH'(2);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_SINGLE  = FLIT_TYPE_WIDTH'(3);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PAYLOAD = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
   logic [VC_WIDTH-1:0]    vc_q, vc_d;
   logic                   full_q, full_d;
   logic [FLIT_WIDTH-1:0]  flit_q, flit_d;

   logic [VCHANNELS-1:0]   vc_onehot;
   logic                   accept;
   logic                   can_load;
   logic                   req_ready_c;
   logic                   data_ready_c;

   // Decode the latched VC; out_ready bits of the other VCs are masked off.
   for (genvar gi = 0; gi < VCHANNELS; gi++) begin : g_vc_dec
      assign vc_onehot[gi] = (vc_q == VC_WIDTH'(gi));
   end

   assign accept   = full_q & (|(vc_onehot & bus.out_ready));
   assign can_load = ~full_q | accept;

   assign bus.out_flit   = flit_q;
   assign bus.out_valid  = full_q ? vc_onehot : '0;
   assign bus.req_ready  = req_ready_c;
   assign bus.data_ready = data_ready_c;

   // Next-state: header build in IDLE, payload streaming in PAYLOAD; the
   // output register refills in the same cycle it drains.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      vc_d         = vc_q;
      flit_d       = flit_q;
      full_d       = full_q & ~accept;
      req_ready_c  = 1'b0;
      data_ready_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready_c = can_load & ~rst;
            if (bus.req_valid && req_ready_c) begin
               full_d = 1'b1;
               // Out-of-range VC requests fall back to VC 0.
               vc_d   = (int'(bus.req_vc) >= VCHANNELS) ? '0 : bus.req_vc;
               if (bus.req_len == '0) begin
                  flit_d = {TYPE_SINGLE, bus.req_dest, bus.req_prio, bus.req_hdr};
               end else begin
                  flit_d      = {TYPE_HEADER, bus.req_dest, bus.req_prio, bus.req_hdr};
                  remaining_d = bus.req_len;
                  state_d     = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            data_ready_c = can_load & ~rst;
            if (bus.data_valid && data_ready_c) begin
               full_d      = 1'b1;
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) begin
                  flit_d  = {TYPE_LAST, bus.data_in};
                  state_d = ST_IDLE;
               end else begin
                  flit_d  = {TYPE_PAYLOAD, bus.data_in};
               end
            end
         end
      endcase
   end

   // State and output register; reset abandons any packet in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         vc_q        <= '0;
         full_q      <= 1'b0;
         flit_q      <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         vc_q        <= vc_d;
         full_q      <= full_d;
         flit_q      <= flit_d;
      end
   end

`ifdef LISNOC_PACKETIZER_STATS_EN
   logic [31:0] stat_q;

   // Count packets leaving the block: LAST and SINGLE share a set type MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else if (accept && flit_q[FLIT_WIDTH-1]) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign stat_packets = stat_q;
`endif

endmodule

// File: doc/lisnoc_packetizer.md
# lisnoc_packetizer

Converts a request-plus-data-word message stream from a tile-side client into lisnoc flits and injects them into a router local input port (flat `flit`/`valid`/`ready` link, one valid/ready bit per virtual channel). The block builds the header flit from destination, priority and header-payload fields. It then streams the payload words, tags the last one, and holds each flit in a single output register until the router accepts it. It is the source stage directly upstream of a router input.

## Interface
- `FLIT_DATA_WIDTH`, 32: flit data bits.
- `FLIT_TYPE_WIDTH`, 2: flit type bits, placed in the MSBs of `out_flit`.
- `VCHANNELS`, 1: virtual channels on the link.
- `VC_WIDTH`, 1: width of `req_vc`. Must be at least clog2(VCHANNELS), minimum 1.
- `PH_DEST_WIDTH`, 5: destination field width, in header data MSBs.
- `PH_PRIO_WIDTH`, 4: priority field width, directly below the destination field.
- `LEN_WIDTH`, 8: width of the payload word count.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  packet request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_dest`  in  PH_DEST_WIDTH  destination.
- `req_prio`  in  PH_PRIO_WIDTH  priority.
- `req_hdr`  in  FLIT_DATA_WIDTH-PH_DEST_WIDTH-PH_PRIO_WIDTH  header payload bits.
- `req_len`  in  LEN_WIDTH  payload words following the header (0 = single-flit packet).
- `req_vc`  in  VC_WIDTH  virtual channel.
- `data_in`  in  FLIT_DATA_WIDTH  payload word.
- `data_valid`  in  1  payload word valid.
- `data_ready`  out  1  payload word accepted when `data_valid & data_ready`.
- `out_flit`  out  FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH  flit to router.
- `out_valid`  out  VCHANNELS  one-hot valid on the packet's VC.
- `out_ready`  in  VCHANNELS  router ready per VC.

## Operation
- Flit types:
  - PAYLOAD = 2'b00
  - HEADER = 2'b01
  - LAST = 2'b10
  - SINGLE = 2'b11
- Header data layout: `{req_dest, req_prio, req_hdr}`, MSB to LSB.
- Output register: holds one flit plus a `full` flag.
  - `can_load = !full | (out_valid[vc_q] & out_ready[vc_q])`.
  - Loading and draining in the same cycle gives one flit per cycle.
- FSM states: IDLE, PAYLOAD.
  - **IDLE:**
    - `req_ready = can_load`; `data_ready = 0`.
    - On request handshake: latch `vc_q` and load the header flit. If `req_vc >= VCHANNELS`, `vc_q = 0`.
    - `req_len == 0`: type SINGLE, stay in IDLE.
    - `req_len != 0`: type HEADER, `remaining = req_len`, go to PAYLOAD.
  - **PAYLOAD:**
    - `req_ready = 0`; `data_ready = can_load`.
    - On data handshake: load `{type, data_in}`, with type LAST if `remaining == 1`, otherwise PAYLOAD.
    - Decrement `remaining`; at `remaining == 1`, return to IDLE.
- `out_valid = full ? (1 << vc_q) : 0`.
- `out_flit` and `out_valid` are stable while `full` and not accepted. Valid never drops without acceptance.
- `out_ready` bits of other VCs are ignored.
- `req_len` is unsigned. The maximum is 2^LEN_WIDTH-1 payload words. There is no wrap.
- Reset mid-packet aborts the packet. The truncated packet is not completed. This case is legal only under system-wide reset.

## Timing
- Reset values:
  - `out_valid = 0`, `out_flit = 0`, `full = 0`.
  - State IDLE, `remaining = 0`, `vc_q = 0`.
  - `req_ready = 0` and `data_ready = 0` while `rst` is high.
- After reset release, `req_ready = 1` in the first cycle.
- Latency: a flit appears on `out_flit`/`out_valid` one cycle after its input handshake.
- `req_ready` and `data_ready` depend combinationally on `out_ready`. There is no combinational path from `req_valid` or `data_valid` to any output.
- Throughput with `out_ready` held high:
  - one flit per cycle;
  - packet of N payload words = N+1 cycles;
  - next request is accepted in the cycle after the last data handshake, with no bubble.
- `data_valid` in IDLE is not consumed. `req_valid` in PAYLOAD is not consumed.

## Configuration
- Macro: `LISNOC_PACKETIZER_STATS_EN`.
- Defined:
  - Adds output `stat_packets` [31:0], reset 0.
  - Increments on each output handshake of a LAST or SINGLE flit.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and its counter are absent. Flit behaviour is identical in both cases.

## Test plan
- **Single-flit packet.** Stimulus: `req_len=0`, `dest=5`, `prio=3`, `hdr=0`, `out_ready=1`. Required response: one flit `{2'b11, 32'h2980_0000}` one cycle later; `req_ready` high the next cycle.
- **Multi-flit packet.** Stimulus: `req_len=3`, data `0xA`, `0xB`, `0xC`, ready always high. Required response: HEADER, PAYLOAD `0xA`, PAYLOAD `0xB`, LAST `0xC` on 4 consecutive cycles.
- **Backpressure.** Stimulus: hold `out_ready=0` for 5 cycles mid-packet. Required response: `out_flit`/`out_valid` stable, `data_ready=0`; the stream resumes unchanged with no loss or duplication.
- **VC routing.** Stimulus: `VCHANNELS=2`, `req_vc=1`; `out_ready` = 2'b01, then 2'b10. Required response: no progress on 2'b01; accepted on 2'b10; `out_valid` = 2'b10 only.
- **Reset mid-packet.** Stimulus: assert `rst` after the header of a `req_len=4` packet. Required response: `out_valid=0` immediately; IDLE after release; a new request is accepted normally.
- **Stats counter.** Stimulus: with `LISNOC_PACKETIZER_STATS_EN`, send 3 packets of lengths 0, 2, 1. Required response: `stat_packets = 3`.
